boot_loader_ctrl: RTL and testbench
===================================

Name: boot_loader_ctrl

Overview:
- Sequences start-up of the Gambling_Tec core: holds the CPU in reset, streams an initial data image into data memory, then releases the CPU.
- Bytes arrive on a valid/ready stream (UART/debug front-end) and are packed little-endian into 32-bit words.
- Each word is written to the data RAM write port at consecutive word addresses.
- Replaces testbench back-door RAM preloading with a synthesizable path.

Parameters:
- NUM_WORDS, 64: words to load before release; legal range 1..65535.
- BASE_ADDR, 32'h0000_0000: byte address of the first word; must be 4-byte aligned.
- RST_HOLD, 4: cycles `cpu_rst` stays high after the last write; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  incoming image byte
- byte_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  data RAM write enable, one-cycle pulse per word
- mem_addr  out  32  byte address; RAM indexes by mem_addr[31:2]
- mem_wdata  out  32  assembled word
- cpu_rst  out  1  reset to Gambling_Tec core
- busy  out  1  load in progress (LOAD, WRITE or HOLD)
- done  out  1  CPU released
- word_count  out  16  words written so far
- err  out  1  checksum failure; 0 unless BOOT_CHECKSUM_EN

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values (and values the cycle after `rst` is sampled high):
  - state=LOAD, byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - cpu_rst=1, busy=1, done=0, word_count=0, err=0.
  - byte index=0; any partial word is discarded.
- States: LOAD, WRITE, HOLD, RUN, plus ERROR (checksum build only).
- All outputs are registered.
- LOAD:
  - byte_ready=1.
  - Handshake completes when byte_valid and byte_ready are both high at a clock edge.
  - Byte k (0..3) lands in word bits [8k+7:8k].
  - On the 4th accepted byte: go to WRITE. mem_wdata holds the full word and mem_addr = BASE_ADDR + 4*word_count.
- WRITE:
  - Exactly one cycle; mem_we=1 and byte_ready=0. byte_valid is ignored and the source must hold the byte.
  - Next edge: word_count increments.
  - If the new count equals NUM_WORDS, go to HOLD; otherwise return to LOAD.
  - Steady-state maximum throughput: 1 word per 5 cycles.
- HOLD:
  - cpu_rst=1, byte_ready=0.
  - Counter runs RST_HOLD cycles, then go to RUN.
- RUN:
  - cpu_rst=0, done=1, busy=0, byte_ready=0, mem_we=0.
  - Terminal state; only `rst` leaves it.
  - Bytes offered in RUN are never accepted.
- Latency: the first RUN cycle is exactly RST_HOLD+1 cycles after the final WRITE cycle.
- Address arithmetic: modulo 2^32, wrapping silently. word_count is 16-bit and never exceeds NUM_WORDS.
- byte_valid low in LOAD: FSM waits indefinitely with no timeout. Accepted-byte count and partial word are retained.
- Reset mid-load: words already written stay in RAM; the load restarts at BASE_ADDR.

Optional Feature:
- Macro: `BOOT_CHECKSUM_EN`.
- With the macro defined:
  - Loader keeps a 32-bit modular sum of all written words.
  - After word NUM_WORDS is written, a 5th-phase word (4 more bytes, little-endian) is received. It is not written to RAM (mem_we stays 0).
  - If it equals the sum: go to HOLD.
  - Otherwise: go to ERROR. In ERROR, err=1, cpu_rst=1, busy=0, done=0, byte_ready=0, until `rst`.
- Without the macro: no sum logic, err tied 0, and HOLD follows the last write directly.

Test Plan:
- Reset check: hold rst 3 cycles -> cpu_rst=1, byte_ready=0, mem_we=0, word_count=0. First cycle after release: byte_ready=1.
- NUM_WORDS=5, BASE_ADDR=0, bytes for words 10,20,30,40,50 streamed back-to-back:
  - Exactly 5 mem_we pulses at addr 0,4,8,12,16 with data 10..50.
  - cpu_rst falls RST_HOLD+1 cycles after the 5th pulse; done=1; RAM[0..4]=10..50.
- Bubbles: byte_valid toggles randomly, byte pattern 0x78,0x56,0x34,0x12 -> mem_wdata=0x12345678. Bytes offered during WRITE are not lost.
- Reset after 2 of 5 words: rst 1 cycle, then full stream -> writes restart at addr 0, word_count restarts at 0, total 5 pulses after reset.
- After done=1, byte_valid held high 20 cycles -> byte_ready=0, no mem_we, word_count stays 5.
- BOOT_CHECKSUM_EN, words 10..50:
  - Checksum 150 -> RUN.
  - Checksum 151 -> err=1, cpu_rst stays 1 for 50 cycles, no 6th write.

Source files
------------

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl
//   Start-up sequencer for the Gambling_Tec core. It holds the CPU in reset,
//   receives a byte stream and packs each group of four bytes little-endian
//   into a 32-bit word. Each word goes to the data RAM write port at
//   consecutive word addresses. Once the image is loaded the CPU stays in
//   reset for RST_HOLD more cycles and is then released.
//
// Optional feature (macro BOOT_CHECKSUM_EN):
//   The image is followed by one extra little-endian word. That word must
//   equal the 32-bit modular sum of all words written. On a match the
//   sequence continues to HOLD; on a mismatch it parks in ERROR with err=1.
//   When the macro is undefined, err is tied to 0 and HOLD follows the last
//   write directly.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   byte_valid  source presents a byte on byte_data
//   byte_data   image byte
//   byte_ready  loader accepts the byte at the next edge
//   mem_we      one-cycle write strobe per word
//   mem_addr    byte address of the word (RAM uses [31:2])
//   mem_wdata   assembled word
//   cpu_rst     reset to the core
//   busy        load in progress (LOAD, WRITE or HOLD)
//   done        core released
//   word_count  words written since reset
//   err         checksum mismatch (checksum build only)
//
// States:
//   state   | meaning
//   S_LOAD  | collecting bytes of the current word (or of the checksum word)
//   S_WRITE | single-cycle RAM write of the assembled word
//   S_HOLD  | image loaded; CPU still held in reset for RST_HOLD cycles
//   S_RUN   | CPU released; terminal until rst
//   S_ERROR | checksum mismatch; terminal until rst

module boot_loader_ctrl #(
  parameter int unsigned NUM_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned RST_HOLD  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count,
  output logic        err
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_WRITE = 3'd1,
    S_HOLD  = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [15:0] NW_LAST   = 16'(NUM_WORDS);
  localparam logic [7:0]  HOLD_LAST = 8'(RST_HOLD - 1);

  state_t      state, state_d;
  logic [1:0]  byte_idx, byte_idx_d;
  logic [23:0] part, part_d;
  logic [7:0]  hold_cnt, hold_cnt_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic [15:0] word_count_d;
  logic        byte_ready_d, mem_we_d, cpu_rst_d, busy_d, done_d;
  logic        accept;
  logic [31:0] word_in;
  logic [15:0] count_inc;

`ifdef BOOT_CHECKSUM_EN
  logic [31:0] sum, sum_d;
  logic        chk_phase, chk_phase_d;
  logic        err_q, err_d;
`endif

  assign accept    = (state == S_LOAD) && byte_valid && byte_ready;
  // Only meaningful when the 4th byte is being accepted.
  assign word_in   = {byte_data, part};
  assign count_inc = word_count + 16'd1;

  always_comb begin
    state_d      = state;
    byte_idx_d   = byte_idx;
    part_d       = part;
    hold_cnt_d   = hold_cnt;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    word_count_d = word_count;
`ifdef BOOT_CHECKSUM_EN
    sum_d        = sum;
    chk_phase_d  = chk_phase;
`endif

    case (state)
      S_LOAD: begin
        if (accept) begin
          if (byte_idx == 2'd3) begin
            byte_idx_d = 2'd0;
`ifdef BOOT_CHECKSUM_EN
            if (chk_phase) begin
              // The checksum word is compared and never written to RAM.
              if (word_in == sum) begin
                state_d    = S_HOLD;
                hold_cnt_d = HOLD_LAST;
              end else begin
                state_d = S_ERROR;
              end
            end else begin
              state_d     = S_WRITE;
              mem_wdata_d = word_in;
            end
`else
            state_d     = S_WRITE;
            mem_wdata_d = word_in;
`endif
          end else begin
            byte_idx_d = byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    part_d[7:0]   = byte_data;
              2'd1:    part_d[15:8]  = byte_data;
              default: part_d[23:16] = byte_data;
            endcase
          end
        end
      end
      S_WRITE: begin
        word_count_d = count_inc;
        mem_addr_d   = mem_addr + 32'd4;
`ifdef BOOT_CHECKSUM_EN
        sum_d = sum + mem_wdata;
        if (count_inc == NW_LAST) begin
          chk_phase_d = 1'b1;
        end
        state_d = S_LOAD;
`else
        if (count_inc == NW_LAST) begin
          state_d    = S_HOLD;
          hold_cnt_d = HOLD_LAST;
        end else begin
          state_d = S_LOAD;
        end
`endif
      end
      S_HOLD: begin
        if (hold_cnt == 8'd0) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt - 8'd1;
        end
      end
      S_RUN:   state_d = S_RUN;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_LOAD;
    endcase

    // Outputs are registered copies of what the next state implies.
    byte_ready_d = (state_d == S_LOAD);
    mem_we_d     = (state_d == S_WRITE);
    cpu_rst_d    = (state_d != S_RUN);
    busy_d       = (state_d == S_LOAD) || (state_d == S_WRITE) || (state_d == S_HOLD);
    done_d       = (state_d == S_RUN);
`ifdef BOOT_CHECKSUM_EN
    err_d        = (state_d == S_ERROR);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOAD;
      byte_idx   <= 2'd0;
      part       <= 24'd0;
      hold_cnt   <= 8'd0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 32'd0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b1;
      done       <= 1'b0;
      word_count <= 16'd0;
`ifdef BOOT_CHECKSUM_EN
      sum        <= 32'd0;
      chk_phase  <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      byte_idx   <= byte_idx_d;
      part       <= part_d;
      hold_cnt   <= hold_cnt_d;
      byte_ready <= byte_ready_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      cpu_rst    <= cpu_rst_d;
      busy       <= busy_d;
      done       <= done_d;
      word_count <= word_count_d;
`ifdef BOOT_CHECKSUM_EN
      sum        <= sum_d;
      chk_phase  <= chk_phase_d;
      err_q      <= err_d;
`endif
    end
  end

`ifdef BOOT_CHECKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl (NUM_WORDS=5, BASE_ADDR=0, RST_HOLD=4).
// Stimulus pushes each expected RAM write into a queue. A negedge monitor
// pops an entry on every mem_we pulse and compares address and data.
module tb_boot_loader_ctrl;
  localparam int NW = 5;
  localparam int RH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic [15:0] word_count;
  logic        err;

  boot_loader_ctrl #(
    .NUM_WORDS(NW),
    .BASE_ADDR(32'h0000_0000),
    .RST_HOLD (RH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .word_count(word_count),
    .err       (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int we_count = 0;
  bit bubbles = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  logic [31:0] ram [0:15];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_count++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, no write expected", mem_addr, mem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", mem_addr, exp_e[63:32]);
        check("wr_data", mem_wdata, exp_e[31:0]);
      end
      ram[mem_addr[5:2]] = mem_wdata;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    if (bubbles) repeat ($urandom_range(0, 2)) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      tests++;
      fails++;
      $display("FAIL byte_timeout: byte_ready still %b, required 1", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] data, input bit push);
    if (push) exp_q.push_back({addr, data});
    for (int k = 0; k < 4; k++) send_byte(data[8*k +: 8]);
  endtask

  task automatic run_image(input logic [31:0] w [5]);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < NW; i++) begin
      send_word(32'(4 * i), w[i], 1'b1);
      s = s + w[i];
    end
`ifdef BOOT_CHECKSUM_EN
    send_word(32'd0, s, 1'b0);
`endif
  endtask

  task automatic wait_run();
    int t;
    t = 0;
    while (cpu_rst !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: cpu_rst still %b, required 0", cpu_rst);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    we_count = 0;
    for (int i = 0; i < 16; i++) ram[i] = 32'd0;
  endtask

  logic [31:0] img1 [5];
  logic [31:0] img2 [5];
  int bad;

  initial begin
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    for (int i = 0; i < 16; i++) ram[i] = 32'd0;
    img1 = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50};
    img2 = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8070_6050};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_byte_ready", 32'(byte_ready), 32'd1);

    // Back-to-back stream of words 10..50
    run_image(img1);
    wait_run();
`ifndef BOOT_CHECKSUM_EN
    check("release_latency", 32'(cyc - last_we_cyc), 32'(RH + 1));
`endif
    check("run_done", 32'(done), 32'd1);
    check("run_busy", 32'(busy), 32'd0);
    check("run_word_count", 32'(word_count), 32'd5);
    check("run_we_count", 32'(we_count), 32'd5);
    for (int i = 0; i < NW; i++) check("ram_img1", ram[i], 32'(10 * (i + 1)));

    // Bytes offered after release are never taken
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (byte_ready !== 1'b0) bad++;
    end
    byte_valid = 1'b0;
    check("run_ready_cycles", 32'(bad), 32'd0);
    check("run_word_count_hold", 32'(word_count), 32'd5);
    check("run_we_count_hold", 32'(we_count), 32'd5);

    // Random bubbles, first word 0x12345678
    pulse_reset();
    bubbles = 1'b1;
    run_image(img2);
    wait_run();
    bubbles = 1'b0;
    check("bub_word_count", 32'(word_count), 32'd5);
    check("bub_we_count", 32'(we_count), 32'd5);
    check("bub_ram0", ram[0], 32'h1234_5678);
    check("bub_ram3", ram[3], 32'hFFFF_FFFF);

    // Reset after two words, then a full reload
    pulse_reset();
    send_word(32'd0, 32'd10, 1'b1);
    send_word(32'd4, 32'd20, 1'b1);
    repeat (2) @(negedge clk);
    check("mid_word_count", 32'(word_count), 32'd2);
    check("mid_mem_addr", mem_addr, 32'd8);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_word_count", 32'(word_count), 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    we_count = 0;
    run_image(img1);
    wait_run();
    check("reload_we_count", 32'(we_count), 32'd5);
    check("reload_word_count", 32'(word_count), 32'd5);
    check("reload_done", 32'(done), 32'd1);

`ifdef BOOT_CHECKSUM_EN
    // Wrong checksum: 151 instead of 150
    pulse_reset();
    for (int i = 0; i < NW; i++) send_word(32'(4 * i), img1[i], 1'b1);
    send_word(32'd0, 32'd151, 1'b0);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (err !== 1'b1 || cpu_rst !== 1'b1) bad++;
    end
    check("chk_bad_cycles", 32'(bad), 32'd0);
    check("chk_done", 32'(done), 32'd0);
    check("chk_busy", 32'(busy), 32'd0);
    check("chk_we_count", 32'(we_count), 32'd5);
`else
    check("err_tied", 32'(err), 32'd0);
`endif

    repeat (2) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
